// File: rtl/icache_assoc.sv
// icache_assoc: 1- or 2-way set-associative instruction cache with true-LRU
// replacement, flush, and a single outstanding line fill.
//   clk_i, rsn_i               clock, asynchronous active-low reset
//   req_i, addr_i              fetch request and byte address
//   flush_i                    invalidate all lines, abort an outstanding miss
//   data_o, hit_o, miss_o      combinational lookup result for addr_i
//   rqst_to_mem_o              one-cycle line-fill request pulse
//   addr_to_mem_o              line-aligned miss address, held while waiting
//   mem_data_ready_i           fill response valid
//   mem_data_i, mem_addr_i     fill line data and its address
module icache_assoc #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] data_o,
  output logic              hit_o,
  output logic              miss_o,
  output logic              rqst_to_mem_o,
  output logic [ADDR_W-1:0] addr_to_mem_o,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] mem_addr_i
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int BOFF_W = $clog2(WORD_W / 8);
  localparam int WSEL_W = OFF_W - BOFF_W;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q;
  logic [SETS-1:0]    valid_q [WAYS];
  logic [SETS-1:0]    lru_q;
  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]  data_q  [WAYS][SETS];
  logic               victim_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [LINE_W-1:0]  hit_line;
  logic               hit_way;
  logic               victim;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               fill_hit;
  logic               fill_en;

  assign idx      = addr_i[OFF_W +: IDX_W];
  assign tag      = addr_i[ADDR_W-1 -: TAG_W];
  assign fill_idx = addr_to_mem_o[OFF_W +: IDX_W];
  assign fill_tag = addr_to_mem_o[ADDR_W-1 -: TAG_W];
  assign fill_hit = (state_q == WAIT) && mem_data_ready_i &&
                    (mem_addr_i[ADDR_W-1:OFF_W] == addr_to_mem_o[ADDR_W-1:OFF_W]);
  assign fill_en  = fill_hit && !flush_i;

  logic unused_ok;
  assign unused_ok = ^{mem_addr_i[OFF_W-1:0], addr_i[BOFF_W-1:0]};

  always_comb begin
    hit_o    = 1'b0;
    hit_way  = 1'b0;
    hit_line = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (req_i && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit_o    = 1'b1;
        hit_way  = w[0];
        hit_line = data_q[w][idx];
      end
    end
  end

  assign miss_o = req_i && !hit_o;

  generate
    if (WSEL_W > 0) begin : g_wsel
      logic [WSEL_W-1:0] word_sel;
      assign word_sel = addr_i[OFF_W-1:BOFF_W];
      assign data_o   = WORD_W'(hit_line >> (WORD_W * word_sel));
    end else begin : g_wsel_none
      assign data_o = hit_line[WORD_W-1:0];
    end

    if (WAYS == 2) begin : g_victim2
      // First invalid way wins (way 0 first); otherwise the LRU way.
      always_comb begin
        if (!valid_q[0][idx])      victim = 1'b0;
        else if (!valid_q[1][idx]) victim = 1'b1;
        else                       victim = lru_q[idx];
      end
    end else begin : g_victim1
      assign victim = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q       <= IDLE;
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      lru_q         <= '0;
      victim_q      <= 1'b0;
      rqst_to_mem_o <= 1'b0;
      addr_to_mem_o <= '0;
    end else if (flush_i) begin
      state_q       <= IDLE;
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      lru_q         <= '0;
      rqst_to_mem_o <= 1'b0;
    end else begin
      rqst_to_mem_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_o) begin
            state_q       <= WAIT;
            rqst_to_mem_o <= 1'b1;
            addr_to_mem_o <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            victim_q      <= victim;
          end else if (hit_o && (WAYS == 2)) begin
            lru_q[idx] <= ~hit_way;
          end
        end
        WAIT: begin
          if (fill_hit) begin
            valid_q[victim_q][fill_idx] <= 1'b1;
            if (WAYS == 2) lru_q[fill_idx] <= ~victim_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; only valid bits qualify their contents.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[victim_q][fill_idx]  <= fill_tag;
      data_q[victim_q][fill_idx] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: default 2-way/4-set instance plus a
// 1-way/8-set instance sharing clock and reset.
module tb_icache_assoc;
  logic          clk = 1'b0;
  logic          rsn = 1'b0;

  logic          req, flush, rdy;
  logic [19:0]   addr, maddr;
  logic [127:0]  mdata;
  logic [31:0]   data;
  logic          hit, miss, rqst;
  logic [19:0]   a2m;

  logic          req1, rdy1;
  logic [19:0]   addr1, maddr1;
  logic [127:0]  mdata1;
  logic [31:0]   data1;
  logic          hit1, miss1, rqst1;
  logic [19:0]   a2m1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icache_assoc dut (
    .clk_i(clk), .rsn_i(rsn), .req_i(req), .addr_i(addr), .flush_i(flush),
    .data_o(data), .hit_o(hit), .miss_o(miss), .rqst_to_mem_o(rqst),
    .addr_to_mem_o(a2m), .mem_data_ready_i(rdy), .mem_data_i(mdata),
    .mem_addr_i(maddr)
  );

  icache_assoc #(.ADDR_W(20), .LINE_W(128), .WORD_W(32), .SETS(8), .WAYS(1)) dut1 (
    .clk_i(clk), .rsn_i(rsn), .req_i(req1), .addr_i(addr1), .flush_i(1'b0),
    .data_o(data1), .hit_o(hit1), .miss_o(miss1), .rqst_to_mem_o(rqst1),
    .addr_to_mem_o(a2m1), .mem_data_ready_i(rdy1), .mem_data_i(mdata1),
    .mem_addr_i(maddr1)
  );

  function automatic logic [127:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic fill(input logic [19:0] a, input logic [127:0] line);
    req = 1'b1; addr = a;
    tick();
    rdy = 1'b1; maddr = a & 20'hFFFF0; mdata = line;
    tick();
    rdy = 1'b0;
  endtask

  task automatic fill1(input logic [19:0] a, input logic [127:0] line);
    req1 = 1'b1; addr1 = a;
    tick();
    rdy1 = 1'b1; maddr1 = a & 20'hFFFF0; mdata1 = line;
    tick();
    rdy1 = 1'b0;
  endtask

  task automatic test_reset;
    req = 1'b1; addr = 20'h00104;
    #3;
    tests++; if (rqst !== 1'b0) begin fails++; $display("FAIL reset_rqst got %b exp 0", rqst); end
    tests++; if (a2m !== 20'h0) begin fails++; $display("FAIL reset_a2m got %h exp 00000", a2m); end
    tests++; if (hit !== 1'b0 || miss !== 1'b1) begin fails++; $display("FAIL reset_lookup got hit=%b miss=%b exp hit=0 miss=1", hit, miss); end
    tests++; if (data !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", data); end
    req = 1'b0;
    tick();
    rsn = 1'b1;
  endtask

  task automatic test_cold_miss;
    req = 1'b1; addr = 20'h00104;
    #1;
    tests++; if (miss !== 1'b1 || hit !== 1'b0) begin fails++; $display("FAIL cold_miss got hit=%b miss=%b exp hit=0 miss=1", hit, miss); end
    tick();
    tests++; if (rqst !== 1'b1) begin fails++; $display("FAIL cold_rqst got %b exp 1", rqst); end
    tests++; if (a2m !== 20'h00100) begin fails++; $display("FAIL cold_a2m got %h exp 00100", a2m); end
    tick();
    tests++; if (rqst !== 1'b0) begin fails++; $display("FAIL cold_pulse got %b exp 0", rqst); end
    tests++; if (a2m !== 20'h00100) begin fails++; $display("FAIL cold_a2m_hold got %h exp 00100", a2m); end
    rdy = 1'b1; maddr = 20'h00100; mdata = {32'h3, 32'h2, 32'hDEADBEEF, 32'h0};
    tick();
    rdy = 1'b0;
    tests++; if (hit !== 1'b1 || data !== 32'hDEADBEEF) begin fails++; $display("FAIL cold_hit got hit=%b data=%h exp hit=1 data=deadbeef", hit, data); end
    addr = 20'h00108;
    #1;
    tests++; if (data !== 32'h2) begin fails++; $display("FAIL cold_word2 got %h exp 00000002", data); end
    req = 1'b0;
    tick();
  endtask

  task automatic test_lru;
    do_flush();
    fill(20'h00100, mk(32'h1000_0000));
    fill(20'h00500, mk(32'h5000_0000));
    addr = 20'h00504;
    #1;
    tests++; if (hit !== 1'b1 || data !== 32'h5000_0001) begin fails++; $display("FAIL lru_hit500 got hit=%b data=%h exp hit=1 data=50000001", hit, data); end
    addr = 20'h00100;
    #1;
    tests++; if (hit !== 1'b1 || data !== 32'h1000_0000) begin fails++; $display("FAIL lru_hit100 got hit=%b data=%h exp hit=1 data=10000000", hit, data); end
    tick();
    fill(20'h00900, mk(32'h9000_0000));
    addr = 20'h0090C;
    #1;
    tests++; if (hit !== 1'b1 || data !== 32'h9000_0003) begin fails++; $display("FAIL lru_hit900 got hit=%b data=%h exp hit=1 data=90000003", hit, data); end
    addr = 20'h00108;
    #1;
    tests++; if (hit !== 1'b1 || data !== 32'h1000_0002) begin fails++; $display("FAIL lru_keep100 got hit=%b data=%h exp hit=1 data=10000002", hit, data); end
    addr = 20'h00500;
    #1;
    tests++; if (hit !== 1'b0 || miss !== 1'b1) begin fails++; $display("FAIL lru_evict500 got hit=%b miss=%b exp hit=0 miss=1", hit, miss); end
    req = 1'b0;
    tick();
  endtask

  task automatic test_wrong_resp;
    do_flush();
    req = 1'b1; addr = 20'h00200;
    tick();
    rdy = 1'b1; maddr = 20'h00300; mdata = mk(32'h3000_0000);
    tick();
    rdy = 1'b0;
    tests++; if (miss !== 1'b1) begin fails++; $display("FAIL wrong_miss got %b exp 1", miss); end
    tests++; if (a2m !== 20'h00200 || rqst !== 1'b0) begin fails++; $display("FAIL wrong_hold got a2m=%h rqst=%b exp a2m=00200 rqst=0", a2m, rqst); end
    rdy = 1'b1; maddr = 20'h0020C; mdata = mk(32'h2000_0000);
    tick();
    rdy = 1'b0;
    tests++; if (hit !== 1'b1 || data !== 32'h2000_0000) begin fails++; $display("FAIL wrong_fill got hit=%b data=%h exp hit=1 data=20000000", hit, data); end
    tick();
  endtask

  task automatic test_flush_mid_miss;
    req = 1'b1; addr = 20'h00400;
    tick();
    tests++; if (rqst !== 1'b1 || a2m !== 20'h00400) begin fails++; $display("FAIL flush_pre got rqst=%b a2m=%h exp rqst=1 a2m=00400", rqst, a2m); end
    req = 1'b0;
    do_flush();
    req = 1'b1; addr = 20'h00200;
    #1;
    tests++; if (hit !== 1'b0 || miss !== 1'b1) begin fails++; $display("FAIL flush_inval got hit=%b miss=%b exp hit=0 miss=1", hit, miss); end
    req = 1'b0;
    rdy = 1'b1; maddr = 20'h00200; mdata = mk(32'h2000_0000);
    tick();
    rdy = 1'b0;
    tests++; if (rqst !== 1'b0) begin fails++; $display("FAIL flush_idle got rqst=%b exp 0", rqst); end
    req = 1'b1; addr = 20'h00200;
    #1;
    tests++; if (miss !== 1'b1) begin fails++; $display("FAIL flush_late_ignored got miss=%b exp 1", miss); end
    tick();
    tests++; if (rqst !== 1'b1 || a2m !== 20'h00200) begin fails++; $display("FAIL flush_rerequest got rqst=%b a2m=%h exp rqst=1 a2m=00200", rqst, a2m); end
    req = 1'b0;
    do_flush();
  endtask

  task automatic test_async_reset;
    fill(20'h00100, mk(32'h1000_0000));
    addr = 20'h00100;
    #1;
    tests++; if (hit !== 1'b1) begin fails++; $display("FAIL arst_pre got hit=%b exp 1", hit); end
    addr = 20'h00300;
    tick();
    #2;
    rsn = 1'b0;
    #1;
    tests++; if (rqst !== 1'b0 || a2m !== 20'h0) begin fails++; $display("FAIL arst_outputs got rqst=%b a2m=%h exp rqst=0 a2m=00000", rqst, a2m); end
    addr = 20'h00100;
    #1;
    tests++; if (hit !== 1'b0 || miss !== 1'b1) begin fails++; $display("FAIL arst_lookup got hit=%b miss=%b exp hit=0 miss=1", hit, miss); end
    req = 1'b0;
    tick();
    rsn = 1'b1;
  endtask

  task automatic test_ways1;
    fill1(20'h00100, mk(32'hA000_0000));
    addr1 = 20'h00104;
    #1;
    tests++; if (hit1 !== 1'b1 || data1 !== 32'hA000_0001) begin fails++; $display("FAIL w1_hit100 got hit=%b data=%h exp hit=1 data=a0000001", hit1, data1); end
    fill1(20'h00900, mk(32'hB000_0000));
    addr1 = 20'h00900;
    #1;
    tests++; if (hit1 !== 1'b1 || data1 !== 32'hB000_0000) begin fails++; $display("FAIL w1_hit900 got hit=%b data=%h exp hit=1 data=b0000000", hit1, data1); end
    addr1 = 20'h00100;
    #1;
    tests++; if (hit1 !== 1'b0 || miss1 !== 1'b1) begin fails++; $display("FAIL w1_evict got hit=%b miss=%b exp hit=0 miss=1", hit1, miss1); end
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    req = 1'b0; addr = '0; flush = 1'b0; rdy = 1'b0; maddr = '0; mdata = '0;
    req1 = 1'b0; addr1 = '0; rdy1 = 1'b0; maddr1 = '0; mdata1 = '0;
    test_reset();
    test_cold_miss();
    test_lru();
    test_wrong_resp();
    test_flush_mid_miss();
    test_async_reset();
    test_ways1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
